// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity receiver: FSM encoding and default frame width.
package serial_parity_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a data word; odd_sel=1 gives the bit that makes the total count odd.
module parity_calc #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         odd_sel,
    output logic         p
);

    // XOR reduction, optionally inverted through an XOR gate to form the XNOR (odd) case
    assign p = (^data) ^ odd_sel;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              exp_par;

    parity_calc #(.W(DATA_W)) u_parity_calc (
        .data    (shift_q),
        .odd_sel (PARITY_ODD),
        .p       (exp_par)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = bit_in;
                    // counter parks on the last index instead of wrapping
                    if (cnt_q == LAST_BIT) state_d = PARITY;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
                PARITY: begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_in) begin
                        rx_data_d    = shift_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = (par_q != exp_par);
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // busy is registered from the next state so it tracks state_q exactly
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench: odd- and even-parity receivers share one randomized bit stream
// and are compared every cycle against a frame-level expectation model.
module tb_serial_parity_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b1;
    logic [DW-1:0] o_data, e_data;
    logic          o_valid, e_valid, o_perr, e_perr, o_ferr, e_ferr, o_busy, e_busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned rv_count = 0;
    bit          check_en = 1'b1;

    // frame-level expectations
    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0, exp_perr_o = 1'b0, exp_perr_e = 1'b0;
    logic          exp_ferr = 1'b0, exp_busy = 1'b0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .rx_data(o_data), .rx_valid(o_valid), .parity_err(o_perr),
        .frame_err(o_ferr), .busy(o_busy)
    );

    serial_parity_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .rx_data(e_data), .rx_valid(e_valid), .parity_err(e_perr),
        .frame_err(e_ferr), .busy(e_busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("odd.rx_data",     16'(o_data),  16'(exp_data));
            chk("odd.rx_valid",    16'(o_valid), 16'(exp_valid));
            chk("odd.parity_err",  16'(o_perr),  16'(exp_perr_o));
            chk("odd.frame_err",   16'(o_ferr),  16'(exp_ferr));
            chk("odd.busy",        16'(o_busy),  16'(exp_busy));
            chk("even.rx_data",    16'(e_data),  16'(exp_data));
            chk("even.rx_valid",   16'(e_valid), 16'(exp_valid));
            chk("even.parity_err", 16'(e_perr),  16'(exp_perr_e));
            chk("even.frame_err",  16'(e_ferr),  16'(exp_ferr));
            chk("even.busy",       16'(e_busy),  16'(exp_busy));
            if (o_valid === 1'b1) rv_count++;
        end
    end

    // one clock: present the inputs, let the DUT sample them, clear one-cycle pulses
    task automatic tick(input bit v, input bit b);
        bit_valid = v;
        bit_in    = v ? b : 1'($urandom);
        @(posedge clk);
        #1;
        exp_valid  = 1'b0;
        exp_perr_o = 1'b0;
        exp_perr_e = 1'b0;
        exp_ferr   = 1'b0;
        bit_valid  = 1'b0;
    endtask

    task automatic gaps(input int unsigned maxgap);
        int unsigned n;
        n = $urandom_range(0, maxgap);
        for (int unsigned g = 0; g < n; g++) tick(1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit pbit, input bit stop,
                              input int unsigned maxgap);
        int unsigned ones;
        gaps(maxgap);
        tick(1'b1, 1'b0);
        exp_busy = 1'b1;
        for (int unsigned i = 0; i < DW; i++) begin
            gaps(maxgap);
            tick(1'b1, d[i]);
        end
        gaps(maxgap);
        tick(1'b1, pbit);
        gaps(maxgap);
        tick(1'b1, stop);
        exp_busy = 1'b0;
        ones = $countones(d);
        if (stop) begin
            exp_data   = d;
            exp_valid  = 1'b1;
            exp_perr_o = (pbit != ((ones % 2) == 0));
            exp_perr_e = (pbit != ((ones % 2) == 1));
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    // start bit plus n data bits, then asynchronous reset in the middle of a cycle
    task automatic abort_frame(input int unsigned n);
        tick(1'b1, 1'b0);
        exp_busy = 1'b1;
        for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'($urandom));
        #1;
        rst_n    = 1'b0;
        exp_busy = 1'b0;
        exp_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int unsigned base;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b1);

        // clean 0xA5 odd frame
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("lit.clean.data",  16'(o_data),  16'h00A5);
        chk("lit.clean.valid", 16'(o_valid), 16'h0001);
        chk("lit.clean.perr",  16'(o_perr),  16'h0000);
        chk("lit.clean.ferr",  16'(o_ferr),  16'h0000);
        chk("lit.clean.even_perr", 16'(e_perr), 16'h0001);
        tick(1'b1, 1'b1);

        // parity error, and even-parity acceptance of the same word
        send_frame(8'hA5, 1'b0, 1'b1, 2);
        chk("lit.perr.valid", 16'(o_valid), 16'h0001);
        chk("lit.perr.perr",  16'(o_perr),  16'h0001);
        chk("lit.even.valid", 16'(e_valid), 16'h0001);
        chk("lit.even.perr",  16'(e_perr),  16'h0000);

        // framing error keeps previous data
        send_frame(8'h07, 1'b0, 1'b0, 1);
        chk("lit.ferr.ferr",  16'(o_ferr),  16'h0001);
        chk("lit.ferr.valid", 16'(o_valid), 16'h0000);
        chk("lit.ferr.data",  16'(o_data),  16'h00A5);

        // reset mid-frame, then a full 0x3C frame
        tick(1'b1, 1'b1);
        base = rv_count;
        abort_frame(4);
        send_frame(8'h3C, 1'b1, 1'b1, 1);
        tick(1'b1, 1'b1);
        chk("lit.rst.count", 16'(rv_count - base), 16'd1);
        chk("lit.rst.data",  16'(o_data), 16'h003C);

        // back-to-back frames with random strobe gaps
        base = rv_count;
        send_frame(8'h01, 1'b0, 1'b1, 5);
        send_frame(8'hFE, 1'b0, 1'b1, 5);
        tick(1'b1, 1'b1);
        chk("lit.b2b.count", 16'(rv_count - base), 16'd2);
        chk("lit.b2b.data",  16'(o_data), 16'h00FE);

        // randomized traffic
        for (int unsigned f = 0; f < 60; f++) begin
            int unsigned idle;
            idle = $urandom_range(0, 2);
            for (int unsigned k = 0; k < idle; k++) tick(1'b1, 1'b1);
            if ($urandom_range(0, 9) == 0)
                abort_frame($urandom_range(0, DW - 1));
            else
                send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                           $urandom_range(0, 3));
        end
        repeat (3) tick(1'b1, 1'b1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
